// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // The bit counter needs at least one bit, even for WIDTH=1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing A - B - Bin, LSB first, with valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the two's-complement overflow output ovf_o.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] res_shift;
  logic             cell_d;
  logic             cell_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_subtractor_cell u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    br_d      = br_q;
    res_d     = res_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    res_shift = res_q >> 1;
    res_shift[WIDTH-1] = cell_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = bin_i;
          cnt_d   = '0;
          state_d = CALC;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a_i[WIDTH-1];
          b_msb_d = b_i[WIDTH-1];
`endif
        end
      end
      CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_bout;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        // The final bit goes straight into the output registers so the result appears with it.
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          diff_d  = res_shift;
          bout_d  = cell_bout;
          state_d = DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign diff_o      = diff_q;
  assign bout_o      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1) and its bit cell.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [7:0] a, b, diff;

  logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_bin, w1_bout;
  logic [0:0] w1_a, w1_b, w1_diff;

  logic       c_a, c_b, c_bin, c_d, c_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf, w1_ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .bin_i       (bin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .diff_o      (diff),
    .bout_o      (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut_w1 (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .in_valid_i  (w1_in_valid),
    .in_ready_o  (w1_in_ready),
    .a_i         (w1_a),
    .b_i         (w1_b),
    .bin_i       (w1_bin),
    .out_valid_o (w1_out_valid),
    .out_ready_i (w1_out_ready),
    .diff_o      (w1_diff),
    .bout_o      (w1_bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf_o       (w1_ovf)
`endif
  );

  full_subtractor_cell u_cell (
    .a_i    (c_a),
    .b_i    (c_b),
    .bin_i  (c_bin),
    .d_o    (c_d),
    .bout_o (c_bout)
  );

  // Presents one operand set while IDLE and returns the number of edges after acceptance until out_valid.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic binv, output int lat);
    a = av;
    b = bv;
    bin = binv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    bin = ~binv;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if ({bout, diff} !== 9'h000) begin miscompares++; $display("[TB] FAIL reset_result: got bout=%b diff=%h want 0/00", bout, diff); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] ta [3] = '{8'h05, 8'h03, 8'h00};
    logic [7:0] tb [3] = '{8'h03, 8'h05, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] ed [3] = '{8'h02, 8'hFE, 8'hFF};
    logic       eb [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tc[i], lat);
      vectors++;
      if (lat != 8) begin miscompares++; $display("[TB] FAIL basic_latency[%0d]: got %0d want 8", i, lat); end
      vectors++;
      if (diff !== ed[i]) begin miscompares++; $display("[TB] FAIL basic_diff[%0d]: got %h want %h", i, diff, ed[i]); end
      vectors++;
      if (bout !== eb[i]) begin miscompares++; $display("[TB] FAIL basic_bout[%0d]: got %b want %b", i, bout, eb[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(8'h33, 8'h11, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 8'hFF;
      b = 8'h00;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_handshake[%0d]: got valid=%b ready=%b want 1/0", i, out_valid, in_ready);
      end
      vectors++;
      if (diff !== 8'h22 || bout !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got diff=%h bout=%b want 22/0", i, diff, bout);
      end
    end
    in_valid = 1'b0;
    consume();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    bit seen;
    a = 8'h55;
    b = 8'h11;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_handshake: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    vectors++;
    if (diff !== 8'h00 || bout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_result: got diff=%h bout=%b want 00/0", diff, bout);
    end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_discard: got out_valid seen=%b want 0", seen); end
    run_op(8'hFF, 8'h01, 1'b0, lat);
    vectors++;
    if (lat != 8 || diff !== 8'hFE || bout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_next_op: got lat=%0d diff=%h bout=%b want 8/FE/0", lat, diff, bout);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int cnt, lat1, lat2;
    logic [7:0] r1d;
    logic r1b;
    out_ready = 1'b1;
    a = 8'hA5;
    b = 8'h5A;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h5A;
    b = 8'hA5;
    cnt = 0;
    lat1 = -1;
    r1d = 8'h00;
    r1b = 1'b0;
    while (cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid) begin lat1 = cnt; r1d = diff; r1b = bout; end
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (cnt + 1 != 10) begin miscompares++; $display("[TB] FAIL b2b_interval: got %0d want 10", cnt + 1); end
    vectors++;
    if (lat1 != 8 || r1d !== 8'h4B || r1b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got lat=%0d diff=%h bout=%b want 8/4B/0", lat1, r1d, r1b);
    end
    lat2 = 0;
    while (!out_valid && lat2 < 40) begin
      @(posedge clk); #1;
      lat2++;
    end
    vectors++;
    if (lat2 != 8 || diff !== 8'hB5 || bout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got lat=%0d diff=%h bout=%b want 8/B5/1", lat2, diff, bout);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf();
    logic [7:0] ta [3] = '{8'h80, 8'h7F, 8'h10};
    logic [7:0] tb [3] = '{8'h01, 8'hFF, 8'h01};
    logic [7:0] ed [3] = '{8'h7F, 8'h80, 8'h0F};
    logic       eb [3] = '{1'b0, 1'b1, 1'b0};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, lat);
      vectors++;
      if (diff !== ed[i] || bout !== eb[i]) begin
        miscompares++;
        $display("[TB] FAIL ovf_result[%0d]: got diff=%h bout=%b want %h/%b", i, diff, bout, ed[i], eb[i]);
      end
      vectors++;
      if (ovf !== eo[i]) begin miscompares++; $display("[TB] FAIL ovf_flag[%0d]: got %b want %b", i, ovf, eo[i]); end
      consume();
    end
  endtask
`endif

  task automatic test_width1();
    logic ta [2] = '{1'b0, 1'b1};
    logic tb [2] = '{1'b1, 1'b1};
    logic tc [2] = '{1'b0, 1'b1};
    logic ed [2] = '{1'b1, 1'b1};
    logic eb [2] = '{1'b1, 1'b1};
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic eo [2] = '{1'b1, 1'b0};
`endif
    int lat;
    for (int i = 0; i < 2; i++) begin
      w1_a = ta[i];
      w1_b = tb[i];
      w1_bin = tc[i];
      w1_in_valid = 1'b1;
      @(posedge clk); #1;
      w1_in_valid = 1'b0;
      w1_a = ~ta[i];
      w1_b = ~tb[i];
      lat = 0;
      while (!w1_out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      vectors++;
      if (lat != 1) begin miscompares++; $display("[TB] FAIL w1_latency[%0d]: got %0d want 1", i, lat); end
      vectors++;
      if (w1_diff[0] !== ed[i] || w1_bout !== eb[i]) begin
        miscompares++;
        $display("[TB] FAIL w1_result[%0d]: got diff=%b bout=%b want %b/%b", i, w1_diff, w1_bout, ed[i], eb[i]);
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      vectors++;
      if (w1_ovf !== eo[i]) begin miscompares++; $display("[TB] FAIL w1_ovf[%0d]: got %b want %b", i, w1_ovf, eo[i]); end
`endif
      w1_out_ready = 1'b1;
      @(posedge clk); #1;
      w1_out_ready = 1'b0;
    end
  endtask

  task automatic test_cell();
    // Truth table indexed by {a, b, bin}.
    logic [7:0] dTab = 8'b1001_0110;
    logic [7:0] bTab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      {c_a, c_b, c_bin} = 3'(i);
      #1;
      vectors++;
      if (c_d !== dTab[i] || c_bout !== bTab[i]) begin
        miscompares++;
        $display("[TB] FAIL cell[%0d]: got d=%b bout=%b want %b/%b", i, c_d, c_bout, dTab[i], bTab[i]);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    bin = 1'b0;
    w1_in_valid = 1'b0;
    w1_out_ready = 1'b0;
    w1_a = 1'b0;
    w1_b = 1'b0;
    w1_bin = 1'b0;
    c_a = 1'b0;
    c_b = 1'b0;
    c_bin = 1'b0;
    test_reset();
    test_cell();
    test_basic();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned/two's-complement subtractor. Computes A - B - Bin, one bit per cycle, LSB first.
- One full-subtractor cell; the borrow is held in a flop between bits.
- Valid/ready handshake on both the operand side and the result side.
- Small-area companion to the ripple full-adder datapath, for low-rate arithmetic where gate count matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
clk_i  input  1  clock; all flops on rising edge.
reset_n_i  input  1  reset, asynchronous, active-low.
in_valid_i  input  1  operands valid.
in_ready_o  output  1  block can accept operands; high only in IDLE.
a_i  input  WIDTH  minuend.
b_i  input  WIDTH  subtrahend.
bin_i  input  1  borrow-in, applied at bit 0.
out_valid_o  output  1  result valid; held until accepted.
out_ready_i  input  1  consumer accepts result.
diff_o  output  WIDTH  difference, (A - B - Bin) mod 2^WIDTH.
bout_o  output  1  final borrow-out; 1 iff A < B + Bin (unsigned).

Behaviour:
- Clock and reset: one clock (clk_i); reset_n_i is asynchronous, active-low.
- Reset values: in_ready_o=1, out_valid_o=0, diff_o=0, bout_o=0, state=IDLE, bit counter=0, borrow flop=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On an edge with in_valid_i=1: register a_i, b_i into shift registers, load the borrow flop with bin_i, clear the counter, go to CALC.
- CALC:
  - in_ready_o=0; in_valid_i is ignored.
  - Each edge processes operand bit k (k = counter):
    - d = a^b^br
    - br_next = (~a & b) | (~(a^b) & br)
    - d shifts into the result register from the MSB side; the operand registers shift right; the counter increments.
  - After the edge that processes bit WIDTH-1: go to DONE, load diff_o and bout_o, set out_valid_o=1.
- Latency: out_valid_o rises exactly WIDTH cycles after the accepting edge.
- DONE:
  - out_valid_o=1; diff_o and bout_o are stable.
  - On an edge with out_ready_i=1: out_valid_o=0, go to IDLE.
  - in_ready_o stays 0 in DONE, so there is no accept-in-same-cycle bypass.
  - Minimum initiation interval: WIDTH+2 cycles.
- Backpressure: with out_ready_i=0, DONE and all outputs hold indefinitely.
- Between results, diff_o and bout_o keep their last values; they are meaningful only when out_valid_o=1.
- WIDTH=1: CALC lasts exactly one cycle.
- Counter width: $clog2(WIDTH) bits, minimum 1.
- Reset mid-operation (any state): immediately return to reset values; the in-flight result is discarded and never presented.
- Any operand change on a_i, b_i or bin_i after acceptance has no effect on the current result.

Optional Feature:
Macro SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output ovf_o (1 bit), two's-complement overflow.
  - ovf_o = (a_msb != b_msb) && (diff_msb != a_msb), using the registered operand MSBs captured at accept.
  - Registered together with diff_o, valid under out_valid_o; reset value 0.
- Undefined: port ovf_o and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_subtractor_pkg holds:
  - state typedef (enum logic [1:0]: IDLE, CALC, DONE)
  - a localparam function for the counter width
- Sub-module full_subtractor_cell (a, b, bin -> d, bout) holds the combinational bit cell.
  - Instantiated once.
  - Unit-testable against the truth table independently of the FSM.

Test Plan:
1. WIDTH=8; A=0x05, B=0x03, Bin=0 -> diff_o=0x02, bout_o=0; out_valid_o rises exactly 8 cycles after the accepting edge.
2. A=0x03, B=0x05, Bin=0 -> diff_o=0xFE, bout_o=1. A=0x00, B=0x00, Bin=1 -> diff_o=0xFF, bout_o=1.
3. Backpressure:
   - Hold out_ready_i=0 for 5 cycles after out_valid_o: result and out_valid_o stay stable, in_ready_o=0, in_valid_i pulses are ignored.
   - Raise out_ready_i: IDLE next cycle, in_ready_o=1.
4. Reset mid-operation:
   - Assert reset_n_i=0 asynchronously (mid-cycle) at bit 3 of CALC: outputs go to reset values without waiting for a clock edge.
   - After release, a new operation with A=0xFF, B=0x01 gives diff_o=0xFE, bout_o=0.
5. Back-to-back operations with out_ready_i tied high: initiation interval is exactly 10 cycles; results are correct for A=0xA5, B=0x5A (0x4B, bout_o=0) followed by A=0x5A, B=0xA5 (0xB5, bout_o=1).
6. SERIAL_SUBTRACTOR_OVF_EN defined:
   - A=0x80, B=0x01 -> diff_o=0x7F, ovf_o=1, bout_o=0.
   - A=0x7F, B=0xFF -> diff_o=0x80, ovf_o=1.
   - A=0x10, B=0x01 -> ovf_o=0.
   - Also run with WIDTH=1: A=0, B=1 -> diff_o=1, bout_o=1, ovf_o=1.
